// File: rtl/htif_pkg.sv
// Shared types for the HTIF PCR host initiator: bus widths, FSM state encoding
// and the latched command record.
package htif_pkg;

  localparam int PCR_ADDR_W = 12;
  localparam int PCR_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REP  = 2'd2,
    RES  = 2'd3
  } htif_pcr_state_e;

  typedef struct packed {
    logic                  rw;
    logic [PCR_ADDR_W-1:0] addr;
    logic [PCR_DATA_W-1:0] wdata;
  } htif_pcr_cmd_t;

endpackage

// File: rtl/htif_timeout_cnt.sv
// Transaction watchdog: restarts on clear, counts while enabled and saturates
// at LIMIT-1, where expire_o stays high until the next clear.
module htif_timeout_cnt #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q, count_d;

  assign expire_o = (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/htif_pcr_master.sv
// Host-side initiator for the core's HTIF PCR port: one outstanding read/write,
// request/reply handshakes, result returned on a valid/ready port.
// Optional watchdog abort is built when HTIF_PCR_TIMEOUT_EN is defined.
module htif_pcr_master
  import htif_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [PCR_ADDR_W-1:0] cmd_addr,
  input  logic [PCR_DATA_W-1:0] cmd_wdata,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [PCR_DATA_W-1:0] res_data,
  output logic                  res_timeout,
  output logic                  pcr_req_valid,
  input  logic                  pcr_req_ready,
  output logic                  pcr_req_rw,
  output logic [PCR_ADDR_W-1:0] pcr_req_addr,
  output logic [PCR_DATA_W-1:0] pcr_req_data,
  input  logic                  pcr_rep_valid,
  output logic                  pcr_rep_ready,
  input  logic [PCR_DATA_W-1:0] pcr_rep_bits,
  output logic                  stray_rep
);

  htif_pcr_state_e       state_q;
  htif_pcr_cmd_t         req_q;
  logic [PCR_DATA_W-1:0] res_data_q;
  logic                  res_timeout_q;
  logic                  stray_q;
  logic                  expire;

`ifdef HTIF_PCR_TIMEOUT_EN
  htif_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == IDLE && cmd_valid),
    .enable_i (state_q == REQ || state_q == REP),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Handshake flags decode from state alone, so no input reaches an output combinationally.
  assign cmd_ready     = (state_q == IDLE);
  assign pcr_req_valid = (state_q == REQ);
  assign res_valid     = (state_q == RES);
  assign pcr_rep_ready = 1'b1;
  assign pcr_req_rw    = req_q.rw;
  assign pcr_req_addr  = req_q.addr;
  assign pcr_req_data  = req_q.wdata;
  assign res_data      = res_data_q;
  assign res_timeout   = res_timeout_q;
  assign stray_rep     = stray_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      // Replies are always accepted; one that nothing is waiting for is dropped and flagged.
      if (pcr_rep_valid && state_q != REP) begin
        stray_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            req_q   <= '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
            state_q <= REQ;
          end
        end
        REQ: begin
          if (pcr_req_ready) begin
            state_q <= REP;
          end else if (expire) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            state_q       <= RES;
          end
        end
        REP: begin
          // A reply landing on the expiry cycle takes priority over the abort.
          if (pcr_rep_valid) begin
            res_data_q    <= pcr_rep_bits;
            res_timeout_q <= 1'b0;
            state_q       <= RES;
          end else if (expire) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            state_q       <= RES;
          end
        end
        RES: begin
          if (res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_htif_pcr_master.sv
// Directed self-checking bench for htif_pcr_master. The timeout scenario is
// built when HTIF_PCR_TIMEOUT_EN is defined; otherwise the indefinite wait is checked.
module tb_htif_pcr_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [11:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_timeout;
  logic        pcr_req_valid;
  logic        pcr_req_ready;
  logic        pcr_req_rw;
  logic [11:0] pcr_req_addr;
  logic [63:0] pcr_req_data;
  logic        pcr_rep_valid;
  logic        pcr_rep_ready;
  logic [63:0] pcr_rep_bits;
  logic        stray_rep;

  int testCount = 0;
  int failCount = 0;
  int hsCount   = 0;

  htif_pcr_master #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rw        (cmd_rw),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_timeout   (res_timeout),
    .pcr_req_valid (pcr_req_valid),
    .pcr_req_ready (pcr_req_ready),
    .pcr_req_rw    (pcr_req_rw),
    .pcr_req_addr  (pcr_req_addr),
    .pcr_req_data  (pcr_req_data),
    .pcr_rep_valid (pcr_rep_valid),
    .pcr_rep_ready (pcr_rep_ready),
    .pcr_rep_bits  (pcr_rep_bits),
    .stray_rep     (stray_rep)
  );

  always #5 clk = ~clk;

  // Counts request handshakes seen by the core side.
  always @(posedge clk) begin
    if (pcr_req_valid && pcr_req_ready) hsCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    testCount++; if (cmd_ready !== 1'b1)     begin failCount++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    testCount++; if (res_valid !== 1'b0)     begin failCount++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    testCount++; if (res_timeout !== 1'b0)   begin failCount++; $display("[TB] FAIL reset_res_timeout: got %b expected 0", res_timeout); end
    testCount++; if (pcr_req_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_req_valid: got %b expected 0", pcr_req_valid); end
    testCount++; if (stray_rep !== 1'b0)     begin failCount++; $display("[TB] FAIL reset_stray: got %b expected 0", stray_rep); end
    testCount++; if (pcr_rep_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_rep_ready: got %b expected 1", pcr_rep_ready); end
    testCount++; if (res_data !== 64'h0)     begin failCount++; $display("[TB] FAIL reset_res_data: got %h expected 0", res_data); end
    testCount++; if ({pcr_req_rw, pcr_req_addr, pcr_req_data} !== 77'h0)
      begin failCount++; $display("[TB] FAIL reset_req_fields: got %b/%h/%h expected 0/0/0", pcr_req_rw, pcr_req_addr, pcr_req_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h01E; cmd_wdata = 64'h0;
    pcr_req_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    testCount++; if (pcr_req_valid !== 1'b1) begin failCount++; $display("[TB] FAIL read_req_valid: got %b expected 1", pcr_req_valid); end
    testCount++; if (pcr_req_addr !== 12'h01E || pcr_req_rw !== 1'b0)
      begin failCount++; $display("[TB] FAIL read_req_fields: got rw=%b addr=%h expected rw=0 addr=01e", pcr_req_rw, pcr_req_addr); end
    tick();
    pcr_req_ready = 1'b0;
    pcr_rep_valid = 1'b1; pcr_rep_bits = 64'hDEAD_BEEF_0000_0001;
    testCount++; if (res_valid !== 1'b0) begin failCount++; $display("[TB] FAIL read_early_res: got %b expected 0", res_valid); end
    tick();
    pcr_rep_valid = 1'b0;
    testCount++; if (res_valid !== 1'b1) begin failCount++; $display("[TB] FAIL read_latency: got res_valid=%b expected 1", res_valid); end
    testCount++; if (res_data !== 64'hDEAD_BEEF_0000_0001) begin failCount++; $display("[TB] FAIL read_data: got %h expected deadbeef00000001", res_data); end
    testCount++; if (res_timeout !== 1'b0) begin failCount++; $display("[TB] FAIL read_timeout: got %b expected 0", res_timeout); end
    testCount++; if (stray_rep !== 1'b0) begin failCount++; $display("[TB] FAIL read_stray: got %b expected 0", stray_rep); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    testCount++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0)
      begin failCount++; $display("[TB] FAIL read_back_idle: got cmd_ready=%b res_valid=%b expected 1/0", cmd_ready, res_valid); end
  endtask

  task automatic test_write_backpressure();
    int hsBase;
    hsBase = hsCount;
    pcr_req_ready = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h51E; cmd_wdata = 64'h5;
    tick();
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 12'h0; cmd_wdata = 64'h0;
    for (int i = 0; i < 5; i++) begin
      testCount++;
      if (pcr_req_valid !== 1'b1 || pcr_req_rw !== 1'b1 || pcr_req_addr !== 12'h51E || pcr_req_data !== 64'h5)
        begin failCount++; $display("[TB] FAIL write_stable[%0d]: got v=%b rw=%b addr=%h data=%h expected 1/1/51e/5", i, pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data); end
      tick();
    end
    pcr_req_ready = 1'b1;
    tick();
    pcr_req_ready = 1'b0;
    testCount++; if (pcr_req_valid !== 1'b0) begin failCount++; $display("[TB] FAIL write_req_drop: got %b expected 0", pcr_req_valid); end
    pcr_rep_valid = 1'b1; pcr_rep_bits = 64'h0000_1234_5678_9ABC;
    tick();
    pcr_rep_valid = 1'b0;
    testCount++; if (hsCount - hsBase !== 1) begin failCount++; $display("[TB] FAIL write_handshakes: got %0d expected 1", hsCount - hsBase); end
    testCount++; if (res_valid !== 1'b1 || res_data !== 64'h0000_1234_5678_9ABC)
      begin failCount++; $display("[TB] FAIL write_result: got v=%b data=%h expected 1/0000123456789abc", res_valid, res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_result_backpressure();
    pcr_req_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h100;
    tick();
    cmd_valid = 1'b0;
    tick();
    pcr_rep_valid = 1'b1; pcr_rep_bits = 64'h0123_4567_CAFE_F00D;
    tick();
    pcr_rep_valid = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 12'h200;
    for (int i = 0; i < 4; i++) begin
      testCount++;
      if (res_valid !== 1'b1 || res_data !== 64'h0123_4567_CAFE_F00D || cmd_ready !== 1'b0)
        begin failCount++; $display("[TB] FAIL resbp_hold[%0d]: got v=%b data=%h cmd_ready=%b expected 1/01234567cafef00d/0", i, res_valid, res_data, cmd_ready); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    testCount++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || pcr_req_valid !== 1'b0)
      begin failCount++; $display("[TB] FAIL resbp_no_early_accept: got cmd_ready=%b res_valid=%b req_valid=%b expected 1/0/0", cmd_ready, res_valid, pcr_req_valid); end
    tick();
    cmd_valid = 1'b0;
    testCount++; if (pcr_req_valid !== 1'b1 || pcr_req_addr !== 12'h200)
      begin failCount++; $display("[TB] FAIL resbp_second_cmd: got v=%b addr=%h expected 1/200", pcr_req_valid, pcr_req_addr); end
    tick();
    pcr_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_rep();
    testCount++; if (pcr_req_valid !== 1'b0 || cmd_ready !== 1'b0 || res_valid !== 1'b0)
      begin failCount++; $display("[TB] FAIL midrep_in_rep: got req_valid=%b cmd_ready=%b res_valid=%b expected 0/0/0", pcr_req_valid, cmd_ready, res_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    testCount++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || pcr_req_valid !== 1'b0 || res_timeout !== 1'b0 || stray_rep !== 1'b0)
      begin failCount++; $display("[TB] FAIL midrep_flags: got cmd_ready=%b res_valid=%b req_valid=%b tmo=%b stray=%b expected 1/0/0/0/0", cmd_ready, res_valid, pcr_req_valid, res_timeout, stray_rep); end
    testCount++; if (res_data !== 64'h0 || pcr_req_addr !== 12'h0 || pcr_req_data !== 64'h0 || pcr_req_rw !== 1'b0)
      begin failCount++; $display("[TB] FAIL midrep_data: got res=%h addr=%h data=%h rw=%b expected zeros", res_data, pcr_req_addr, pcr_req_data, pcr_req_rw); end
    pcr_rep_valid = 1'b1; pcr_rep_bits = 64'h77;
    tick();
    pcr_rep_valid = 1'b0;
    testCount++; if (stray_rep !== 1'b1 || cmd_ready !== 1'b1)
      begin failCount++; $display("[TB] FAIL midrep_stray: got stray=%b cmd_ready=%b expected 1/1", stray_rep, cmd_ready); end
    tick();
    testCount++; if (stray_rep !== 1'b1) begin failCount++; $display("[TB] FAIL stray_sticky: got %b expected 1", stray_rep); end
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    testCount++; if (stray_rep !== 1'b0) begin failCount++; $display("[TB] FAIL tmo_stray_cleared: got %b expected 0", stray_rep); end
    pcr_req_ready = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h7FF;
    tick();
    cmd_valid = 1'b0;
`ifdef HTIF_PCR_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    testCount++; if (pcr_req_valid !== 1'b1 || res_valid !== 1'b0)
      begin failCount++; $display("[TB] FAIL tmo_before_expiry: got req_valid=%b res_valid=%b expected 1/0", pcr_req_valid, res_valid); end
    tick();
    testCount++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_data !== 64'h0 || pcr_req_valid !== 1'b0)
      begin failCount++; $display("[TB] FAIL tmo_result: got v=%b tmo=%b data=%h req_valid=%b expected 1/1/0/0", res_valid, res_timeout, res_data, pcr_req_valid); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    testCount++; if (stray_rep !== 1'b0 || cmd_ready !== 1'b1)
      begin failCount++; $display("[TB] FAIL tmo_idle: got stray=%b cmd_ready=%b expected 0/1", stray_rep, cmd_ready); end
    pcr_rep_valid = 1'b1; pcr_rep_bits = 64'h99;
    tick();
    pcr_rep_valid = 1'b0;
    testCount++; if (stray_rep !== 1'b1) begin failCount++; $display("[TB] FAIL tmo_late_stray: got %b expected 1", stray_rep); end
`else
    for (int i = 0; i < 40; i++) tick();
    testCount++; if (pcr_req_valid !== 1'b1 || res_valid !== 1'b0 || res_timeout !== 1'b0)
      begin failCount++; $display("[TB] FAIL wait_req: got req_valid=%b res_valid=%b tmo=%b expected 1/0/0", pcr_req_valid, res_valid, res_timeout); end
    pcr_req_ready = 1'b1;
    tick();
    pcr_req_ready = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    testCount++; if (res_valid !== 1'b0 || cmd_ready !== 1'b0)
      begin failCount++; $display("[TB] FAIL wait_rep: got res_valid=%b cmd_ready=%b expected 0/0", res_valid, cmd_ready); end
    pcr_rep_valid = 1'b1; pcr_rep_bits = 64'hABCD;
    tick();
    pcr_rep_valid = 1'b0;
    testCount++; if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_data !== 64'hABCD || stray_rep !== 1'b0)
      begin failCount++; $display("[TB] FAIL wait_result: got v=%b tmo=%b data=%h stray=%b expected 1/0/abcd/0", res_valid, res_timeout, res_data, stray_rep); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    res_ready = 1'b0; pcr_req_ready = 1'b0; pcr_rep_valid = 1'b0; pcr_rep_bits = '0;
    test_reset();
    test_read();
    test_write_backpressure();
    test_result_backpressure();
    test_reset_mid_rep();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
